// File: rtl/irq_ctrl.sv
// Priority interrupt controller on the Peribus: latches rises into pending,
// raises one request at a time to the CPU, and waits for ack and then EOI.
module irq_ctrl #(
  parameter int unsigned NUM_SRC = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [1:0]         addr,
  input  logic [15:0]        write_data,
  input  logic               write_en,
  input  logic               read_en,
  input  logic               chipselect,
  output logic [15:0]        read_data,
  input  logic [NUM_SRC-1:0] irq_src,
  output logic               cpu_irq,
  output logic [2:0]         cpu_vector,
  input  logic               cpu_ack
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    REQUEST = 2'b01,
    SERVICE = 2'b10
  } state_t;

  state_t             state, state_n;
  logic [NUM_SRC-1:0] src_q, rise_q;
  logic [NUM_SRC-1:0] pending, pending_n, enable;
  logic [NUM_SRC-1:0] active, vec_mask, clr_mask;
  logic [2:0]         vector_n, lowest;
  logic               found, ack_clr;
  logic               wr_pend, wr_enable, wr_eoi, rd_sel;
  logic [15:0]        pend16, en16, status16;
  logic [1:0]         state_bits;

  assign wr_pend   = chipselect && write_en && (addr == 2'd0);
  assign wr_enable = chipselect && write_en && (addr == 2'd1);
  assign wr_eoi    = chipselect && write_en && (addr == 2'd3);
  assign rd_sel    = chipselect && read_en;

  assign active  = pending & enable;
  assign cpu_irq = (state == REQUEST);

  always_comb begin
    lowest   = '0;
    found    = 1'b0;
    vec_mask = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (active[i] && !found) begin
        lowest = 3'(i);
        found  = 1'b1;
      end
      vec_mask[i] = (3'(i) == cpu_vector);
    end
  end

  always_comb begin
    state_n  = state;
    vector_n = cpu_vector;
    ack_clr  = 1'b0;
    case (state)
      IDLE: begin
        if (|active) begin
          vector_n = lowest;
          state_n  = REQUEST;
        end
      end
      REQUEST: begin
        // ack wins over a retract seen in the same cycle
        if (cpu_ack) begin
          ack_clr = 1'b1;
          state_n = SERVICE;
        end else if (!(|(active & vec_mask))) begin
          state_n = IDLE;
        end
      end
      SERVICE: begin
        if (wr_eoi) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // A registered rise is OR-ed in last so it beats both W1C and the ack clear.
  always_comb begin
    clr_mask = '0;
    if (wr_pend) clr_mask = clr_mask | write_data[NUM_SRC-1:0];
    if (ack_clr) clr_mask = clr_mask | vec_mask;
    pending_n = (pending & ~clr_mask) | rise_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      src_q      <= irq_src;
      rise_q     <= '0;
      pending    <= '0;
      enable     <= '0;
      state      <= IDLE;
      cpu_vector <= '0;
    end else begin
      src_q      <= irq_src;
      rise_q     <= irq_src & ~src_q;
      pending    <= pending_n;
      if (wr_enable) enable <= write_data[NUM_SRC-1:0];
      state      <= state_n;
      cpu_vector <= vector_n;
    end
  end

  always_comb begin
    pend16 = '0;
    en16   = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      pend16[i] = pending[i];
      en16[i]   = enable[i];
    end
    state_bits = state;
    status16   = {cpu_irq, state_bits, 10'b0, cpu_vector};
  end

  always_comb begin
    read_data = '0;
    if (rd_sel) begin
      case (addr)
        2'd0:    read_data = pend16;
        2'd1:    read_data = en16;
        2'd2:    read_data = status16;
        default: read_data = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: walks the request/ack/EOI flow, retract,
// W1C-vs-rise collision and asynchronous reset with hand-computed values.
module tb_irq_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  addr;
  logic [15:0] write_data;
  logic        write_en;
  logic        read_en;
  logic        chipselect;
  logic [15:0] read_data;
  logic [7:0]  irq_src;
  logic        cpu_irq;
  logic [2:0]  cpu_vector;
  logic        cpu_ack;

  int unsigned assert_count = 0;
  int unsigned fail_count   = 0;

  irq_ctrl #(.NUM_SRC(8)) dut (
    .clock      (clock),
    .reset      (reset),
    .addr       (addr),
    .write_data (write_data),
    .write_en   (write_en),
    .read_en    (read_en),
    .chipselect (chipselect),
    .read_data  (read_data),
    .irq_src    (irq_src),
    .cpu_irq    (cpu_irq),
    .cpu_vector (cpu_vector),
    .cpu_ack    (cpu_ack)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    assert_count++;
    if (got !== exp) begin
      fail_count++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(negedge clock);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [15:0] d);
    addr       = a;
    write_data = d;
    chipselect = 1'b1;
    write_en   = 1'b1;
    @(negedge clock);
    chipselect = 1'b0;
    write_en   = 1'b0;
    write_data = '0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [15:0] d);
    addr       = a;
    chipselect = 1'b1;
    read_en    = 1'b1;
    #1;
    d          = read_data;
    chipselect = 1'b0;
    read_en    = 1'b0;
  endtask

  task automatic ack_pulse();
    cpu_ack = 1'b1;
    @(negedge clock);
    cpu_ack = 1'b0;
  endtask

  logic [15:0] rd;

  initial begin
    reset = 1'b1; addr = '0; write_data = '0; write_en = 1'b0;
    read_en = 1'b0; chipselect = 1'b0; cpu_ack = 1'b0;
    irq_src = 8'h01;

    // Source high through reset must not register a rise
    tick(2);
    reset = 1'b0;
    tick(4);
    bus_read(2'd0, rd); check_eq("reset_pending", rd, 16'h0000);
    check_eq("reset_cpu_irq", {15'b0, cpu_irq}, 16'h0000);
    bus_read(2'd2, rd); check_eq("reset_status", rd, 16'h0000);

    // ack and EOI ignored in IDLE
    cpu_ack = 1'b1; tick(1); cpu_ack = 1'b0;
    bus_write(2'd3, 16'h0000);
    bus_read(2'd2, rd); check_eq("idle_ack_eoi_ignored", rd, 16'h0000);

    // Two simultaneous rises, lowest index wins
    irq_src = 8'h00; tick(1);
    bus_write(2'd1, 16'h0005);
    bus_read(2'd1, rd); check_eq("enable_rb", rd, 16'h0005);
    irq_src = 8'h05;
    tick(1);
    check_eq("lat_edge1_irq", {15'b0, cpu_irq}, 16'h0000);
    tick(1);
    bus_read(2'd0, rd); check_eq("pending_05", rd, 16'h0005);
    check_eq("lat_edge2_irq", {15'b0, cpu_irq}, 16'h0000);
    addr = 2'd0; chipselect = 1'b1; read_en = 1'b0; #1;
    check_eq("read_gated", read_data, 16'h0000);
    chipselect = 1'b0;
    tick(1);
    check_eq("lat_edge3_irq", {15'b0, cpu_irq}, 16'h0001);
    check_eq("vector_0", {13'b0, cpu_vector}, 16'h0000);
    bus_read(2'd2, rd); check_eq("status_req_v0", rd, 16'hA000);

    // Ack then EOI, next source follows
    ack_pulse();
    bus_read(2'd0, rd); check_eq("pending_after_ack", rd, 16'h0004);
    bus_read(2'd2, rd); check_eq("status_service", rd, 16'h4000);
    bus_write(2'd3, 16'h0000);
    bus_read(2'd2, rd); check_eq("status_after_eoi", rd, 16'h0000);
    tick(1);
    check_eq("irq_v2", {15'b0, cpu_irq}, 16'h0001);
    bus_read(2'd2, rd); check_eq("status_req_v2", rd, 16'hA002);
    bus_read(2'd3, rd); check_eq("eoi_reads_0", rd, 16'h0000);
    ack_pulse();
    bus_write(2'd3, 16'h0000);
    bus_read(2'd0, rd); check_eq("pending_drained", rd, 16'h0000);

    // Retract via enable clear
    bus_write(2'd1, 16'h0002);
    irq_src = 8'h07;
    tick(3);
    bus_read(2'd2, rd); check_eq("status_req_v1", rd, 16'hA001);
    bus_write(2'd1, 16'h0000);
    tick(1);
    check_eq("retract_irq", {15'b0, cpu_irq}, 16'h0000);
    bus_read(2'd2, rd); check_eq("retract_status", rd, 16'h0001);
    bus_read(2'd0, rd); check_eq("retract_pending", rd, 16'h0002);

    // W1C colliding with a registered rise on bit 3
    irq_src = 8'h0F;
    tick(1);
    bus_write(2'd0, 16'h0008);
    bus_read(2'd0, rd); check_eq("w1c_vs_rise", rd, 16'h000A);
    bus_write(2'd0, 16'h0008);
    bus_read(2'd0, rd); check_eq("w1c_clear_b3", rd, 16'h0002);
    bus_write(2'd0, 16'h0002);
    bus_read(2'd0, rd); check_eq("w1c_clear_b1", rd, 16'h0000);

    // Asynchronous reset while in SERVICE
    bus_write(2'd1, 16'h0001);
    irq_src = 8'h0E; tick(1);
    irq_src = 8'h0F; tick(3);
    check_eq("pre_reset_irq", {15'b0, cpu_irq}, 16'h0001);
    ack_pulse();
    bus_read(2'd2, rd); check_eq("pre_reset_service", rd, 16'h4000);
    reset = 1'b1;
    #1;
    check_eq("async_reset_irq", {15'b0, cpu_irq}, 16'h0000);
    bus_read(2'd2, rd); check_eq("async_reset_status", rd, 16'h0000);
    bus_read(2'd1, rd); check_eq("async_reset_enable", rd, 16'h0000);
    tick(1);
    reset = 1'b0;
    tick(4);
    bus_read(2'd0, rd); check_eq("post_reset_pending", rd, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
